// File: rtl/oam_dma_pkg.sv
// Shared definitions for the sprite DMA engine: bus addresses,
// FSM state encoding and the page/index address helper.
package oam_dma_pkg;

    // CPU write to this address starts a sprite copy
    localparam logic [15:0] DMA_REG_ADDR  = 16'h4014;
    // PPU OAMDATA port, target of every copied byte
    localparam logic [15:0] OAM_PORT_ADDR = 16'h2004;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HALT  = 3'd1,
        ST_ALIGN = 3'd2,
        ST_READ  = 3'd3,
        ST_WRITE = 3'd4
    } dma_state_e;

    // Source address of byte idx within CPU page
    function automatic logic [15:0] page_addr(input logic [7:0] page, input logic [7:0] idx);
        return {page, idx};
    endfunction

endpackage

// File: rtl/oam_dma.sv
// Sprite DMA engine: snoops the $4014 trigger write, stalls the CPU and
// copies one 256-byte CPU page into OAM as alternating read / $2004 write
// cycles. All bus outputs are registered; each edge loads the values for
// the state being entered.
module oam_dma
    import oam_dma_pkg::*;
#(
    parameter logic [15:0] DMA_REG  = DMA_REG_ADDR,
    parameter logic [15:0] OAM_PORT = OAM_PORT_ADDR
) (
    input  logic        i_cpu_clk,
    input  logic        i_cpu_rstn,
    input  logic [15:0] i_bus_addr,
    input  logic        i_bus_wn,
    input  logic [7:0]  i_bus_wdata,
    output logic        o_cpu_halt,
    output logic [15:0] o_dma_addr,
    output logic        o_dma_wn,
    output logic [7:0]  o_dma_wdata,
    input  logic [7:0]  i_dma_rdata
);

    dma_state_e r_state;
    logic [7:0] r_page;
    logic [7:0] r_idx;
    logic [7:0] r_data;
    logic       r_odd;
    logic       trigger;

    assign trigger = (i_bus_addr == DMA_REG) && !i_bus_wn;

    // The latched byte is driven only during WRITE; it is cleared on leaving
    // WRITE so the data bus idles at zero everywhere else.
    assign o_dma_wdata = r_data;

    // Copy sequencer with registered bus outputs and free-running parity
    always_ff @(posedge i_cpu_clk or negedge i_cpu_rstn) begin
        if (!i_cpu_rstn) begin
            r_state    <= ST_IDLE;
            r_page     <= 8'h00;
            r_idx      <= 8'h00;
            r_data     <= 8'h00;
            r_odd      <= 1'b0;
            o_cpu_halt <= 1'b0;
            o_dma_addr <= 16'h0000;
            o_dma_wn   <= 1'b1;
        end else begin
            // Parity tracks the CPU get/put phase regardless of state
            r_odd <= ~r_odd;
            case (r_state)
                ST_IDLE: begin
                    if (trigger) begin
                        r_state    <= ST_HALT;
                        r_page     <= i_bus_wdata;
                        r_idx      <= 8'h00;
                        o_cpu_halt <= 1'b1;
                    end
                end
                ST_HALT: begin
                    // Reads must fall on odd cycles; insert ALIGN if HALT is odd
                    if (!r_odd) begin
                        r_state    <= ST_READ;
                        o_dma_addr <= page_addr(r_page, r_idx);
                        o_dma_wn   <= 1'b1;
                    end else begin
                        r_state <= ST_ALIGN;
                    end
                end
                ST_ALIGN: begin
                    r_state    <= ST_READ;
                    o_dma_addr <= page_addr(r_page, r_idx);
                    o_dma_wn   <= 1'b1;
                end
                ST_READ: begin
                    r_state    <= ST_WRITE;
                    r_data     <= i_dma_rdata;
                    o_dma_addr <= OAM_PORT;
                    o_dma_wn   <= 1'b0;
                end
                ST_WRITE: begin
                    r_idx  <= r_idx + 8'd1;
                    r_data <= 8'h00;
                    if (r_idx != 8'hFF) begin
                        r_state    <= ST_READ;
                        o_dma_addr <= page_addr(r_page, r_idx + 8'd1);
                        o_dma_wn   <= 1'b1;
                    end else begin
                        r_state    <= ST_IDLE;
                        o_cpu_halt <= 1'b0;
                        o_dma_addr <= 16'h0000;
                        o_dma_wn   <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    o_cpu_halt <= 1'b0;
                    o_dma_addr <= 16'h0000;
                    o_dma_wn   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_oam_dma.sv
// Bench for oam_dma: models CPU RAM and PPU OAM, drives trigger writes at a
// chosen parity and scoreboards every $2004 byte against the RAM model.
module tb_oam_dma;

    logic        i_cpu_clk;
    logic        i_cpu_rstn;
    logic [15:0] i_bus_addr;
    logic        i_bus_wn;
    logic [7:0]  i_bus_wdata;
    logic        o_cpu_halt;
    logic [15:0] o_dma_addr;
    logic        o_dma_wn;
    logic [7:0]  o_dma_wdata;
    logic [7:0]  i_dma_rdata;

    logic [7:0]  mem [0:65535];
    logic [7:0]  oam [0:255];
    logic [7:0]  exp_q [$];
    int          checks;
    int          errors;
    int          ecnt;

    oam_dma dut (
        .i_cpu_clk   (i_cpu_clk),
        .i_cpu_rstn  (i_cpu_rstn),
        .i_bus_addr  (i_bus_addr),
        .i_bus_wn    (i_bus_wn),
        .i_bus_wdata (i_bus_wdata),
        .o_cpu_halt  (o_cpu_halt),
        .o_dma_addr  (o_dma_addr),
        .o_dma_wn    (o_dma_wn),
        .o_dma_wdata (o_dma_wdata),
        .i_dma_rdata (i_dma_rdata)
    );

    initial i_cpu_clk = 1'b0;
    always #5 i_cpu_clk = ~i_cpu_clk;

    // Bus slave: read data valid in the same cycle as the address
    assign i_dma_rdata = mem[o_dma_addr];

    // Edges since reset release; its LSB is the expected parity
    always @(posedge i_cpu_clk or negedge i_cpu_rstn) begin
        if (!i_cpu_rstn) ecnt <= 0;
        else             ecnt <= ecnt + 1;
    end

    task automatic bus_idle();
        i_bus_addr  = 16'h0000;
        i_bus_wn    = 1'b1;
        i_bus_wdata = 8'h00;
    endtask

    // Trigger a copy of page and follow it to the end (or abort after
    // abort_n writes). even selects HALT parity r_odd==0.
    task automatic do_transfer(input logic [7:0] page, input bit even,
                               input int abort_n, input int exp_cycles);
        int halt_cyc, reads, writes, oam_ptr;
        logic [15:0] last_rd, rd_exp, a;
        logic [7:0] eb;
        bit aborted;
        halt_cyc = 0; reads = 0; writes = 0; oam_ptr = 0; aborted = 0;
        last_rd = 16'h0000;
        exp_q.delete();
        for (int i = 0; i < 256; i++) begin
            a = {page, i[7:0]};
            exp_q.push_back(mem[a]);
        end
        while ((ecnt % 2) != (even ? 1 : 0)) @(negedge i_cpu_clk);
        i_bus_addr = 16'h4014; i_bus_wn = 1'b0; i_bus_wdata = page;
        @(negedge i_cpu_clk);
        bus_idle();
        checks++;
        if (o_cpu_halt !== 1'b1) begin
            errors++;
            $display("FAIL halt_rise page=%h got=%b want=1", page, o_cpu_halt);
        end
        for (int cyc = 0; cyc < 700 && o_cpu_halt === 1'b1; cyc++) begin
            halt_cyc++;
            if (o_dma_wn === 1'b0) begin
                checks++;
                if (o_dma_addr !== 16'h2004 || (ecnt % 2) != 0) begin
                    errors++;
                    $display("FAIL write_cycle #%0d addr=%h parity=%0d want 2004/0", writes, o_dma_addr, ecnt % 2);
                end
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL extra_write got=%h want none", o_dma_wdata);
                end else begin
                    eb = exp_q.pop_front();
                    if (o_dma_wdata !== eb) begin
                        errors++;
                        $display("FAIL oam_byte #%0d got=%h want=%h", writes, o_dma_wdata, eb);
                    end
                end
                oam[oam_ptr[7:0]] = o_dma_wdata;
                oam_ptr++;
                writes++;
                if (abort_n != 0 && writes == abort_n) begin
                    @(negedge i_cpu_clk);
                    i_cpu_rstn = 1'b0;
                    #1;
                    checks++;
                    if (o_cpu_halt !== 1'b0 || o_dma_wn !== 1'b1 || o_dma_addr !== 16'h0000) begin
                        errors++;
                        $display("FAIL abort_release halt=%b wn=%b addr=%h want 0/1/0000", o_cpu_halt, o_dma_wn, o_dma_addr);
                    end
                    aborted = 1;
                    break;
                end
            end else if (o_dma_addr != 16'h0000) begin
                rd_exp = {page, reads[7:0]};
                checks++;
                if (o_dma_addr !== rd_exp || (ecnt % 2) != 1) begin
                    errors++;
                    $display("FAIL read_cycle #%0d addr=%h parity=%0d want %h/1", reads, o_dma_addr, ecnt % 2, rd_exp);
                end
                last_rd = o_dma_addr;
                reads++;
            end
            @(negedge i_cpu_clk);
        end
        if (aborted) begin
            // Hold reset a few cycles: no $2004 writes may appear
            for (int k = 0; k < 4; k++) begin
                @(negedge i_cpu_clk);
                checks++;
                if (o_cpu_halt !== 1'b0 || o_dma_wn !== 1'b1) begin
                    errors++;
                    $display("FAIL abort_quiet halt=%b wn=%b want 0/1", o_cpu_halt, o_dma_wn);
                end
            end
            i_cpu_rstn = 1'b1;
            exp_q.delete();
        end else begin
            checks++;
            if (halt_cyc != exp_cycles) begin
                errors++;
                $display("FAIL halt_length page=%h got=%0d want=%0d", page, halt_cyc, exp_cycles);
            end
            checks++;
            if (reads != 256 || writes != 256 || exp_q.size() != 0) begin
                errors++;
                $display("FAIL xfer_count reads=%0d writes=%0d left=%0d want 256/256/0", reads, writes, exp_q.size());
            end
            checks++;
            if (last_rd !== {page, 8'hFF}) begin
                errors++;
                $display("FAIL last_read got=%h want=%h", last_rd, {page, 8'hFF});
            end
            for (int i = 0; i < 256; i++) begin
                a = {page, i[7:0]};
                checks++;
                if (oam[i] !== mem[a]) begin
                    errors++;
                    $display("FAIL oam_image[%0d] got=%h want=%h", i, oam[i], mem[a]);
                end
            end
        end
    endtask

    task automatic test_reset();
        i_cpu_rstn = 1'b0;
        bus_idle();
        repeat (3) @(negedge i_cpu_clk);
        checks++;
        if (o_cpu_halt !== 1'b0 || o_dma_wn !== 1'b1 || o_dma_addr !== 16'h0000 || o_dma_wdata !== 8'h00) begin
            errors++;
            $display("FAIL reset_values halt=%b wn=%b addr=%h wdata=%h want 0/1/0000/00",
                     o_cpu_halt, o_dma_wn, o_dma_addr, o_dma_wdata);
        end
        i_cpu_rstn = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge i_cpu_clk);
            checks++;
            if (o_cpu_halt !== 1'b0 || o_dma_wn !== 1'b1 || o_dma_addr !== 16'h0000) begin
                errors++;
                $display("FAIL idle_after_reset halt=%b wn=%b addr=%h want 0/1/0000", o_cpu_halt, o_dma_wn, o_dma_addr);
            end
        end
    endtask

    task automatic test_non_trigger();
        logic [15:0] addrs [3];
        logic        wns   [3];
        addrs[0] = 16'h4013; wns[0] = 1'b0;
        addrs[1] = 16'h4015; wns[1] = 1'b0;
        addrs[2] = 16'h4014; wns[2] = 1'b1;
        for (int t = 0; t < 3; t++) begin
            i_bus_addr = addrs[t]; i_bus_wn = wns[t]; i_bus_wdata = 8'h07;
            @(negedge i_cpu_clk);
            bus_idle();
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (o_cpu_halt !== 1'b0 || o_dma_wn !== 1'b1 || o_dma_addr !== 16'h0000) begin
                    errors++;
                    $display("FAIL non_trigger %h wn=%b halt=%b dwn=%b daddr=%h want 0/1/0000",
                             addrs[t], wns[t], o_cpu_halt, o_dma_wn, o_dma_addr);
                end
                @(negedge i_cpu_clk);
            end
        end
    endtask

    task automatic test_even_phase();  do_transfer(8'h02, 1'b1, 0, 513); endtask
    task automatic test_odd_phase();   do_transfer(8'h02, 1'b0, 0, 514); endtask
    task automatic test_wrap();        do_transfer(8'hFF, 1'b1, 0, 513); endtask
    task automatic test_back_to_back(); do_transfer(8'h03, 1'b0, 0, 514); endtask

    task automatic test_reset_mid();
        do_transfer(8'h40, 1'b1, 100, 0);
        repeat (2) @(negedge i_cpu_clk);
        do_transfer(8'h20, 1'b1, 0, 513);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int a = 0; a < 65536; a++) begin
            if (a[15:8] == 8'hFF) mem[a] = a[7:0] ^ 8'h5A;
            else                  mem[a] = a[15:8] * 8'd7 + a[7:0] * 8'd3 + 8'd1;
        end
        for (int i = 0; i < 256; i++) oam[i] = 8'h00;
        test_reset();
        test_non_trigger();
        test_even_phase();
        test_odd_phase();
        test_wrap();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
